gen_multitap: RTL and testbench

//  Four-player multitap controller ("Team Player" style) that shares one controller port among four pads.
//  It sits between gen_io port data/control and four pad input sets. Host TH starts a read frame; each
//  TR toggle requests the next nibble; TL acknowledges. It serializes a header, per-slot type codes,

---
 rtl/gen_mtap_pkg.sv | 47 ++++
 rtl/mtap_ack_timer.sv | 29 ++
 rtl/gen_multitap.sv | 165 ++++++++++++++++
 tb/tb_gen_multitap.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/gen_mtap_pkg.sv
// Shared types and constants for the four-slot multitap: frame states, nibble codes,
// pad word bit positions and the per-phase nibble packing.
package gen_mtap_pkg;

  typedef enum logic [2:0] {IDLE, HEADER, TYPES, DATA, END} state_t;

  localparam logic [3:0] HDR0      = 4'h3;
  localparam logic [3:0] HDR1      = 4'hF;
  localparam logic [3:0] HDR2      = 4'h0;
  localparam logic [3:0] HDR3      = 4'h0;
  localparam logic [3:0] TYPE_NONE = 4'hF;
  localparam logic [3:0] TYPE_3B   = 4'h0;
  localparam logic [3:0] TYPE_6B   = 4'h1;
  localparam logic [3:0] NIB_END   = 4'hF;

  localparam int IDX_FIRST_TYPE = 4;
  localparam int IDX_FIRST_DATA = 8;
  localparam int MAX_DATA       = 12;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_MODE  = 8;
  localparam int BTN_X     = 9;
  localparam int BTN_Y     = 10;
  localparam int BTN_Z     = 11;

  function automatic logic [3:0] type_nib(input logic en, input logic six);
    if (!en)     return TYPE_NONE;
    else if (six) return TYPE_6B;
    else         return TYPE_3B;
  endfunction

  function automatic logic [3:0] phase_nib(input logic [11:0] w, input logic [1:0] ph);
    case (ph)
      2'd0:    return {w[BTN_RIGHT], w[BTN_LEFT], w[BTN_DOWN], w[BTN_UP]};
      2'd1:    return {w[BTN_START], w[BTN_A], w[BTN_C], w[BTN_B]};
      default: return {w[BTN_MODE], w[BTN_X], w[BTN_Y], w[BTN_Z]};
    endcase
  endfunction

endpackage

// File: rtl/mtap_ack_timer.sv
// Acknowledge delay: load arms DELAY CE ticks, expire pulses on the last one; clr drops it at once.
// No backpressure; load is ignored while a count is running.
module mtap_ack_timer #(
  parameter int unsigned DELAY = 32
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ce,
  input  logic clr,
  input  logic load,
  output logic expire,
  output logic idle
);

  logic [7:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      cnt <= '0;
    end else if (ce) begin
      if (load && cnt == 8'd0) cnt <= 8'(DELAY);
      else if (cnt != 8'd0)    cnt <= cnt - 8'd1;
    end
  end

  assign expire = ce && !clr && (cnt == 8'd1);
  assign idle   = (cnt == 8'd0);

endmodule

// File: rtl/gen_multitap.sv
// Four-pad multitap: TH starts a frame, each TR toggle returns the next nibble with TL after ACK_DELAY CE.
// DO is registered; the host paces the stream, an unanswered TR edge simply stays pending.
module gen_multitap
  import gen_mtap_pkg::*;
#(
  parameter int unsigned ACK_DELAY = 32,
  parameter int unsigned TH_FILTER = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic [3:0]  PAD_EN,
  input  logic [3:0]  PAD_6B,
  input  logic [47:0] PAD_BTN,
  input  logic        TH,
  input  logic        TR,
  output logic [4:0]  DO,
  output logic        BUSY
);

  logic       thf;
  logic [3:0] thf_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      thf     <= 1'b1;
      thf_cnt <= '0;
    end else if (CE) begin
      if (TH != thf) begin
        if (thf_cnt == 4'(TH_FILTER - 1)) begin
          thf     <= TH;
          thf_cnt <= '0;
        end else begin
          thf_cnt <= thf_cnt + 4'd1;
        end
      end else begin
        thf_cnt <= '0;
      end
    end
  end

  state_t                      state, state_nxt;
  logic [4:0]                  idx, idx_nxt;
  logic [4:0]                  do_q, do_nxt;
  logic [3:0]                  en_q, en_nxt, six_q, six_nxt;
  logic [MAX_DATA-1:0][3:0]    tbl_d, tbl_q, tbl_nxt;
  logic [3:0]                  nd_d, nd_q, nd_nxt;
  logic                        tmr_clr, tmr_load, tmr_expire, tmr_idle;

  // Data nibble order {slot, phase}, compacted over present slots at frame start.
  always_comb begin
    tbl_d = '0;
    nd_d  = '0;
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < 3; p++) begin
        if (PAD_EN[s] && (p < 2 || PAD_6B[s])) begin
          tbl_d[nd_d] = {2'(s), 2'(p)};
          nd_d        = nd_d + 4'd1;
        end
      end
    end
  end

  logic [4:0] end_idx, idx_adv, didx;
  logic [3:0] ent, nib_adv;

  assign end_idx = 5'(IDX_FIRST_DATA) + {1'b0, nd_q};
  assign idx_adv = (idx < end_idx) ? idx + 5'd1 : idx;
  assign didx    = idx_adv - 5'(IDX_FIRST_DATA);
  assign ent     = (didx < 5'(MAX_DATA)) ? tbl_q[didx[3:0]] : 4'h0;

  always_comb begin
    nib_adv = NIB_END;
    if (idx_adv < 5'(IDX_FIRST_TYPE)) begin
      case (idx_adv[1:0])
        2'd0:    nib_adv = HDR0;
        2'd1:    nib_adv = HDR1;
        2'd2:    nib_adv = HDR2;
        default: nib_adv = HDR3;
      endcase
    end else if (idx_adv < 5'(IDX_FIRST_DATA)) begin
      nib_adv = type_nib(en_q[idx_adv[1:0]], six_q[idx_adv[1:0]]);
    end else if (idx_adv < end_idx) begin
      nib_adv = phase_nib(PAD_BTN[12*ent[3:2] +: 12], ent[1:0]);
    end
  end

  function automatic state_t state_of(input logic [4:0] i, input logic [4:0] e);
    if (i < 5'(IDX_FIRST_TYPE))      return HEADER;
    else if (i < 5'(IDX_FIRST_DATA)) return TYPES;
    else if (i < e)                  return DATA;
    else                             return END;
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    do_nxt    = do_q;
    en_nxt    = en_q;
    six_nxt   = six_q;
    tbl_nxt   = tbl_q;
    nd_nxt    = nd_q;
    tmr_clr   = 1'b0;
    tmr_load  = 1'b0;
    if (state == IDLE) begin
      do_nxt  = {1'b1, HDR0};
      idx_nxt = '0;
      if (!thf) begin
        state_nxt = HEADER;
        do_nxt    = {TR, HDR0};
        en_nxt    = PAD_EN;
        six_nxt   = PAD_6B;
        tbl_nxt   = tbl_d;
        nd_nxt    = nd_d;
      end
    end else if (thf) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      do_nxt    = {1'b1, HDR0};
      tmr_clr   = 1'b1;
    end else begin
      tmr_load = (TR != do_q[4]) && tmr_idle;
      // A TR that toggled back before expiry leaves nothing to acknowledge.
      if (tmr_expire && TR != do_q[4]) begin
        idx_nxt   = idx_adv;
        do_nxt    = {TR, nib_adv};
        state_nxt = state_of(idx_adv, end_idx);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      idx   <= '0;
      do_q  <= {1'b1, HDR0};
      en_q  <= '0;
      six_q <= '0;
      tbl_q <= '0;
      nd_q  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      do_q  <= do_nxt;
      en_q  <= en_nxt;
      six_q <= six_nxt;
      tbl_q <= tbl_nxt;
      nd_q  <= nd_nxt;
    end
  end

  mtap_ack_timer #(.DELAY(ACK_DELAY)) u_ack_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .ce     (CE),
    .clr    (tmr_clr),
    .load   (tmr_load),
    .expire (tmr_expire),
    .idle   (tmr_idle)
  );

  assign DO   = do_q;
  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_gen_multitap.sv
// Directed bench for gen_multitap: idle output, TH filter, nibble stream, ack timing, abort and reset.
module tb_gen_multitap;

  localparam int ACK = 32;
  localparam int THF = 4;

  logic        CLK = 1'b0;
  logic        RESET, CE, TH, TR;
  logic [3:0]  PAD_EN, PAD_6B;
  logic [47:0] PAD_BTN;
  logic [4:0]  DO;
  logic        BUSY;

  int checks = 0;
  int errors = 0;
  bit ce_alt = 1'b0;

  gen_multitap #(.ACK_DELAY(ACK), .TH_FILTER(THF)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .PAD_EN(PAD_EN), .PAD_6B(PAD_6B),
    .PAD_BTN(PAD_BTN), .TH(TH), .TR(TR), .DO(DO), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not reach its end in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      if (ce_alt) CE = ~CE;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Toggle TR, confirm TL holds for ACK-1 ticks after the load tick, then DO = {TR, nib}.
  task automatic ack(input string tag, input logic [3:0] nib);
    TR = ~TR;
    tick(ACK);
    chk({tag, "_hold"}, {7'b0, DO[4]}, {7'b0, ~TR});
    tick(1);
    chk(tag, {3'b0, DO}, {3'b0, TR, nib});
  endtask

  task automatic start_frame();
    TH = 1'b0;
    tick(THF);
    chk("start_pre", {7'b0, BUSY}, 8'h00);
    tick(1);
    chk("start_busy", {7'b0, BUSY}, 8'h01);
    chk("start_do", {3'b0, DO}, {3'b0, TR, 4'h3});
  endtask

  initial begin
    RESET = 1'b1; CE = 1'b1; TH = 1'b1; TR = 1'b0;
    PAD_EN = 4'h0; PAD_6B = 4'h0; PAD_BTN = '1;
    tick(2);
    chk("reset_do", {3'b0, DO}, 8'h13);
    chk("reset_busy", {7'b0, BUSY}, 8'h00);
    RESET = 1'b0;

    // Idle with CE at half rate: output pinned to {1,3}.
    ce_alt = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      chk("idle", {2'b0, BUSY, DO}, 8'h13);
    end
    ce_alt = 1'b0; CE = 1'b1;

    // TH glitch shorter than the filter must not open a frame.
    TH = 1'b0;
    tick(THF - 1);
    TH = 1'b1;
    tick(10);
    chk("glitch_busy", {7'b0, BUSY}, 8'h00);
    chk("glitch_do", {3'b0, DO}, 8'h13);

    // Frame: A 3-button, B 6-button; mask changes after start must not matter.
    PAD_EN = 4'b0011; PAD_6B = 4'b0010;
    start_frame();
    PAD_EN = 4'b0000; PAD_6B = 4'b0000;
    ack("hdr1", 4'hF);
    ack("hdr2", 4'h0);
    ack("hdr3", 4'h0);
    ack("typeA", 4'h0);
    ack("typeB", 4'h1);
    ack("typeC", 4'hF);
    ack("typeD", 4'hF);

    // A: UP+START pressed; B: X pressed.
    PAD_BTN = {24'hFFFFFF, 12'hDFF, 12'hF7E};
    ack("A_dir", 4'hE);
    ack("A_btn", 4'h7);
    ack("B_dir", 4'hF);
    ack("B_btn", 4'hF);
    ack("B_ext", 4'hB);
    ack("end0", 4'hF);
    ack("end1", 4'hF);

    // Half-rate CE: the delay stretches to 2*ACK clocks.
    ce_alt = 1'b1; CE = 1'b1;
    TR = ~TR;
    tick(2 * ACK);
    chk("halfce_hold", {7'b0, DO[4]}, {7'b0, ~TR});
    tick(1);
    chk("halfce", {3'b0, DO}, {3'b0, TR, 4'hF});
    ce_alt = 1'b0; CE = 1'b1;

    // Close the frame via TH.
    TH = 1'b1;
    tick(THF);
    chk("close_pre", {7'b0, BUSY}, 8'h01);
    tick(1);
    chk("close", {2'b0, BUSY, DO}, 8'h13);

    // Abort during DATA with an acknowledge pending.
    PAD_EN = 4'b0001; PAD_6B = 4'b0000; PAD_BTN = '1;
    start_frame();
    ack("f2_hdr1", 4'hF);
    ack("f2_hdr2", 4'h0);
    ack("f2_hdr3", 4'h0);
    ack("f2_typeA", 4'h0);
    ack("f2_typeB", 4'hF);
    ack("f2_typeC", 4'hF);
    ack("f2_typeD", 4'hF);
    ack("f2_A_dir", 4'hF);
    TR = ~TR;
    tick(10);
    TH = 1'b1;
    tick(THF + 1);
    chk("abort", {2'b0, BUSY, DO}, 8'h13);
    tick(ACK);
    chk("abort_late", {2'b0, BUSY, DO}, 8'h13);

    // TR double toggle inside the delay: no advance, TL unchanged.
    start_frame();
    TR = ~TR;
    tick(5);
    TR = ~TR;
    tick(ACK + 8);
    chk("dbl_toggle", {3'b0, DO}, {3'b0, TR, 4'h3});
    ack("f3_hdr1", 4'hF);

    // RESET mid-frame with an ack pending.
    TR = ~TR;
    tick(10);
    RESET = 1'b1; TH = 1'b1;
    tick(1);
    RESET = 1'b0;
    chk("midreset", {2'b0, BUSY, DO}, 8'h13);
    tick(ACK + 5);
    chk("midreset_late", {2'b0, BUSY, DO}, 8'h13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
